fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier.
// Stage 1 unpacks and classifies the operands, sums the exponents and forms the sign.
// Stage 2 multiplies the mantissas, hidden bit included.
// Stage 3 normalises, rounds, adjusts the exponent and selects special results.
// One advance signal moves the whole pipeline, so a stalled consumer freezes every stage.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int RNE   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [2:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;        // signed working exponent width
  localparam int MW = MAN_W + 1;        // mantissa width including hidden bit
  localparam int PW = 2 * MW;           // full product width

  localparam logic [EXP_W-1:0]        EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]        EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0]        MAN_ZERO = {MAN_W{1'b0}};
  localparam logic signed [EW-1:0]    E_ZERO   = {EW{1'b0}};
  localparam logic signed [EW-1:0]    E_ONE    = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0]    BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0]    EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]            QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic                    USE_RNE  = (RNE != 32'sd0);

  localparam logic [2:0] FLG_NONE = 3'b000;
  localparam logic [2:0] FLG_INV  = 3'b100;
  localparam logic [2:0] FLG_OVF  = 3'b010;
  localparam logic [2:0] FLG_UNF  = 3'b001;

  // Field classification helpers; a zero exponent (zero or subnormal) counts as zero.
  function automatic logic fp_is_nan(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] != MAN_ZERO);
  endfunction

  function automatic logic fp_is_inf(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] == MAN_ZERO);
  endfunction

  function automatic logic fp_is_zero(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ZERO);
  endfunction

  logic advance_s;

  // Stage 1 combinational signals
  logic                 a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic                 s1_nan_nxt_s, s1_inv_nxt_s, s1_inf_nxt_s, s1_zero_nxt_s;
  logic signed [EW-1:0] s1_exp_nxt_s;

  // Stage 1 registers
  logic                 s1_valid_r, s1_sign_r, s1_nan_r, s1_inv_r, s1_inf_r, s1_zero_r;
  logic signed [EW-1:0] s1_exp_r;
  logic [MW-1:0]        s1_man_a_r, s1_man_b_r;

  // Stage 2 registers
  logic                 s2_valid_r, s2_sign_r, s2_nan_r, s2_inv_r, s2_inf_r, s2_zero_r;
  logic signed [EW-1:0] s2_exp_r;
  logic [PW-1:0]        s2_prod_r;

  // Stage 3 combinational signals
  logic                 norm_hi_s, guard_s, sticky_s, round_up_s;
  logic [MW-1:0]        mant_s;
  logic [MW:0]          mant_rnd_s;
  logic [MAN_W-1:0]     frac_s;
  logic signed [EW-1:0] exp_norm_s, exp_fin_s;
  logic [W-1:0]         c_nxt_s;
  logic [2:0]           flags_nxt_s;

  // Output registers
  logic                 out_valid_r;
  logic [W-1:0]         c_r;
  logic [2:0]           flags_r;

  assign advance_s = !out_valid_r || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign c         = c_r;
  assign flags     = flags_r;

  // Classify operands and form the unnormalised biased exponent.
  always_comb begin
    a_nan_s       = fp_is_nan(a);
    b_nan_s       = fp_is_nan(b);
    a_inf_s       = fp_is_inf(a);
    b_inf_s       = fp_is_inf(b);
    a_zero_s      = fp_is_zero(a);
    b_zero_s      = fp_is_zero(b);
    s1_nan_nxt_s  = a_nan_s || b_nan_s;
    s1_inv_nxt_s  = (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s);
    s1_inf_nxt_s  = a_inf_s || b_inf_s;
    s1_zero_nxt_s = a_zero_s || b_zero_s;
    s1_exp_nxt_s  = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS;
  end

  // Stage 1 register: capture classification, exponent sum, sign and mantissas.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_nan_r   <= 1'b0;
      s1_inv_r   <= 1'b0;
      s1_inf_r   <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_exp_r   <= E_ZERO;
      s1_man_a_r <= {MW{1'b0}};
      s1_man_b_r <= {MW{1'b0}};
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      s1_sign_r  <= a[W-1] ^ b[W-1];
      s1_nan_r   <= s1_nan_nxt_s;
      s1_inv_r   <= s1_inv_nxt_s;
      s1_inf_r   <= s1_inf_nxt_s;
      s1_zero_r  <= s1_zero_nxt_s;
      s1_exp_r   <= s1_exp_nxt_s;
      s1_man_a_r <= {1'b1, a[MAN_W-1:0]};
      s1_man_b_r <= {1'b1, b[MAN_W-1:0]};
    end
  end

  // Stage 2 register: full-width mantissa product plus carried-along control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_nan_r   <= 1'b0;
      s2_inv_r   <= 1'b0;
      s2_inf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_exp_r   <= E_ZERO;
      s2_prod_r  <= {PW{1'b0}};
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_nan_r   <= s1_nan_r;
      s2_inv_r   <= s1_inv_r;
      s2_inf_r   <= s1_inf_r;
      s2_zero_r  <= s1_zero_r;
      s2_exp_r   <= s1_exp_r;
      s2_prod_r  <= {{MW{1'b0}}, s1_man_a_r} * {{MW{1'b0}}, s1_man_b_r};
    end
  end

  // Normalise the product (at most one bit of shift) and round it.
  always_comb begin
    norm_hi_s = s2_prod_r[PW-1];
    if (norm_hi_s) begin
      mant_s     = s2_prod_r[PW-1:MAN_W+1];
      guard_s    = s2_prod_r[MAN_W];
      sticky_s   = |s2_prod_r[MAN_W-1:0];
      exp_norm_s = s2_exp_r + E_ONE;
    end else begin
      mant_s     = s2_prod_r[PW-2:MAN_W];
      guard_s    = s2_prod_r[MAN_W-1];
      sticky_s   = |s2_prod_r[MAN_W-2:0];
      exp_norm_s = s2_exp_r;
    end
    round_up_s = USE_RNE && guard_s && (sticky_s || mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {{MW{1'b0}}, round_up_s};
    // A carry out of rounding leaves 10.00..0, which renormalises to 1.00..0.
    if (mant_rnd_s[MW]) begin
      frac_s    = mant_rnd_s[MAN_W:1];
      exp_fin_s = exp_norm_s + E_ONE;
    end else begin
      frac_s    = mant_rnd_s[MAN_W-1:0];
      exp_fin_s = exp_norm_s;
    end
  end

  // Pick the final encoding in priority order: NaN, Inf x 0, Inf, zero, overflow, underflow, normal.
  always_comb begin
    c_nxt_s     = {W{1'b0}};
    flags_nxt_s = FLG_NONE;
    if (s2_nan_r) begin
      c_nxt_s     = QNAN;
      flags_nxt_s = FLG_NONE;
    end else if (s2_inv_r) begin
      c_nxt_s     = QNAN;
      flags_nxt_s = FLG_INV;
    end else if (s2_inf_r) begin
      c_nxt_s     = {s2_sign_r, EXP_ONES, MAN_ZERO};
      flags_nxt_s = FLG_NONE;
    end else if (s2_zero_r) begin
      c_nxt_s     = {s2_sign_r, EXP_ZERO, MAN_ZERO};
      flags_nxt_s = FLG_NONE;
    end else if (exp_fin_s >= EXP_MAX) begin
      c_nxt_s     = {s2_sign_r, EXP_ONES, MAN_ZERO};
      flags_nxt_s = FLG_OVF;
    end else if (exp_fin_s < E_ONE) begin
      c_nxt_s     = {s2_sign_r, EXP_ZERO, MAN_ZERO};
      flags_nxt_s = FLG_UNF;
    end else begin
      c_nxt_s     = {s2_sign_r, exp_fin_s[EXP_W-1:0], frac_s};
      flags_nxt_s = FLG_NONE;
    end
  end

  // Output register: load a result only when stage 2 holds one; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      c_r         <= {W{1'b0}};
      flags_r     <= FLG_NONE;
    end else if (advance_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        c_r     <= c_nxt_s;
        flags_r <= flags_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: scoreboard bench for fp_mul_pipe (binary32), one RNE and one truncating instance.
module tb_fp_mul_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          has_exp;
    logic [31:0] c0;
    logic [2:0]  f0;
    logic [31:0] c1;
    logic [2:0]  f1;
  } op_t;

  typedef struct {
    logic [31:0] c0;
    logic [2:0]  f0;
    logic [31:0] c1;
    logic [2:0]  f1;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic [2:0]  flags;
  logic        in_ready_t, out_valid_t;
  logic [31:0] c_t;
  logic [2:0]  flags_t;

  op_t  pend[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(0)) dut_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .a(a), .b(b),
    .out_valid(out_valid_t), .out_ready(out_ready), .c(c_t), .flags(flags_t)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit rne);
    logic        s;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic [47:0] p, q, rem, half;
    bit          nx, ny, ix, iy, zx, zy;
    int          e, sh;
    s  = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    nx = (ex == 8'hFF) && (fx != 0);
    ny = (ey == 8'hFF) && (fy != 0);
    ix = (ex == 8'hFF) && (fx == 0);
    iy = (ey == 8'hFF) && (fy == 0);
    zx = (ex == 8'h00);
    zy = (ey == 8'h00);
    if (nx || ny) return {3'b000, 32'h7FC00000};
    if ((ix && zy) || (zx && iy)) return {3'b100, 32'h7FC00000};
    if (ix || iy) return {3'b000, s, 8'hFF, 23'h0};
    if (zx || zy) return {3'b000, s, 31'h0};
    p  = {24'h0, 1'b1, fx} * {24'h0, 1'b1, fy};
    e  = int'(ex) + int'(ey) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e = e + 1;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'h1 << (sh - 1);
    if (rne && ((rem > half) || ((rem == half) && q[0]))) q = q + 48'h1;
    if (q >= 48'h1000000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          sel;
    logic [31:0] r;
    sel = $urandom_range(0, 15);
    r   = $urandom;
    if (sel == 0) r[30:23] = 8'h00;
    else if (sel == 1) r[30:23] = 8'hFF;
    else if (sel < 4) r = r;
    else r[30:23] = 8'($urandom_range(100, 154));
    return r;
  endfunction

  task automatic add_op(input logic [31:0] x, input logic [31:0] y);
    op_t o;
    o.a = x; o.b = y; o.has_exp = 1'b0;
    o.c0 = '0; o.f0 = '0; o.c1 = '0; o.f1 = '0;
    pend.push_back(o);
  endtask

  task automatic add_dir(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] c0, input logic [2:0] f0,
                         input logic [31:0] c1, input logic [2:0] f1);
    op_t o;
    o.a = x; o.b = y; o.has_exp = 1'b1;
    o.c0 = c0; o.f0 = f0; o.c1 = c1; o.f1 = f1;
    pend.push_back(o);
  endtask

  // One cycle: drive at the falling edge, then judge what the coming rising edge will transfer.
  task automatic step(input bit ordy, input bit stall_chk);
    exp_t        e;
    op_t         o;
    logic [34:0] r0, r1;
    @(negedge clk);
    cyc++;
    out_ready = ordy;
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      a = pend[0].a;
      b = pend[0].b;
    end else begin
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
    end
    #1;
    if (stall_chk) begin
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_valid", out_valid, 1);
      if (sb.size() > 0) check_eq("stall_c_hold", c, sb[0].c0);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        n_out++;
        check_eq("c_rne", c, e.c0);
        check_eq("flags_rne", flags, e.f0);
        check_eq("valid_trn", out_valid_t, 1);
        check_eq("c_trn", c_t, e.c1);
        check_eq("flags_trn", flags_t, e.f1);
        if (chk_lat) check_eq("latency", cyc - e.cyc, 3);
      end
    end
    if (in_valid && in_ready) begin
      o = pend.pop_front();
      if (o.has_exp) begin
        e.c0 = o.c0; e.f0 = o.f0; e.c1 = o.c1; e.f1 = o.f1;
      end else begin
        r0 = ref_mul(o.a, o.b, 1'b1);
        r1 = ref_mul(o.a, o.b, 1'b0);
        e.c0 = r0[31:0]; e.f0 = r0[34:32];
        e.c1 = r1[31:0]; e.f1 = r1[34:32];
      end
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic run(input int max_cyc, input int rdy_pct, input bit lat);
    int n;
    n = 0;
    chk_lat = lat;
    while (((pend.size() > 0) || (sb.size() > 0)) && (n < max_cyc)) begin
      step($urandom_range(0, 99) < rdy_pct, 1'b0);
      n++;
    end
    check_eq("drain", pend.size() + sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_c", c, 0);
    check_eq("rst_flags", flags, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // Directed cases, including the rounding tie and all special paths.
    add_dir(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 32'h40400000, 3'b000);
    add_dir(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 32'h3FC00001, 3'b000);
    add_dir(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 32'h7FC00000, 3'b100);
    add_dir(32'h7F000000, 32'hFF000000, 32'hFF800000, 3'b010, 32'hFF800000, 3'b010);
    add_dir(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 32'h00000000, 3'b001);
    add_dir(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b000, 32'h7FC00000, 3'b000);
    add_dir(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000);
    add_dir(32'h80000000, 32'h40400000, 32'h80000000, 3'b000, 32'h80000000, 3'b000);
    add_dir(32'h3F800000, 32'hBF800000, 32'hBF800000, 3'b000, 32'hBF800000, 3'b000);
    add_dir(32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b100, 32'h7FC00000, 3'b100);
    run(60, 100, 1'b1);

    // Random operands at full rate, checking latency.
    for (int i = 0; i < 60; i++) add_op(rand_op(), rand_op());
    run(200, 100, 1'b1);

    // Random operands with random consumer back-pressure.
    for (int i = 0; i < 200; i++) add_op(rand_op(), rand_op());
    run(2000, 65, 1'b0);

    // Five back-to-back products with the consumer stalled in cycles 4-6.
    chk_lat = 1'b0;
    n_out = 0;
    for (int i = 0; i < 5; i++) add_op(rand_op(), rand_op());
    for (int k = 1; k <= 14; k++) step(!((k >= 4) && (k <= 6)), (k >= 4) && (k <= 6));
    check_eq("stall_count", n_out, 5);
    check_eq("stall_drain", pend.size() + sb.size(), 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) add_op(32'h3F800000 + 32'(i), 32'h40000000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_valid_trn", out_valid_t, 0);
    check_eq("midrst_c", c, 0);
    check_eq("midrst_flags", flags, 0);
    sb.delete();
    pend.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      check_eq("postrst_stale", out_valid, 0);
    end

    // Pipeline still works after the mid-flight reset.
    add_dir(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 32'h40400000, 3'b000);
    run(20, 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
